rvtu_div_sched: RTL and testbench

Multi-requester scheduler for one shared external sequential divider (33-bit signed DW_div_seq, early_start, ~6-cycle latency). It takes valid/ready divide/remainder requests from NREQ lanes and grants them round-robin. It sequences the divider's start/complete handshake and returns tagged responses. A one-entry result memo lets a DIV/REM pair on identical operands finish without a second divider pass.

---
 rtl/rvtu_div_sched.sv | 145 ++++++++++++++
 tb/tb_rvtu_div_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvtu_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rvtu_div_sched
//  Description : Round-robin scheduler sharing one sequential divider among
//                NREQ lanes, with a one-entry memo for DIV/REM operand pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvtu_div_sched #(
    parameter int NREQ    = 4,
    parameter int MEMO_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_src1,
    input  logic [NREQ*32-1:0] req_src2,
    input  logic [NREQ*2-1:0] req_fsel,
    output logic [NREQ-1:0]   resp_valid,
    output logic [31:0]       resp_data,
    output logic              div_start,
    output logic [32:0]       div_src1,
    output logic [32:0]       div_src2,
    input  logic              div_complete,
    input  logic              div0,
    input  logic [32:0]       div_quotient,
    input  logic [32:0]       div_rem,
    output logic              busy
);

    localparam int PTR_W = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       r_state;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_tag;
    logic [31:0]      r_src1;
    logic [31:0]      r_src2;
    logic [1:0]       r_fsel;
    logic             r_memo_valid;
    logic [31:0]      r_memo_a;
    logic [31:0]      r_memo_b;
    logic             r_memo_signed;
    logic [31:0]      r_memo_q;
    logic [31:0]      r_memo_r;

    logic             w_any;
    logic [PTR_W-1:0] w_grant;
    logic [PTR_W-1:0] w_next_ptr;
    logic [31:0]      w_src1;
    logic [31:0]      w_src2;
    logic [1:0]       w_fsel;
    logic             w_hit;
    logic             w_unused_bits;

    // Scanning a doubled request vector from rr_ptr gives the circular search
    // without any modulo on a variable index.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < 2 * NREQ; i++) begin
            if (!w_any && (i >= int'(r_rr_ptr)) && req_valid[i % NREQ]) begin
                w_any   = 1'b1;
                w_grant = PTR_W'(i % NREQ);
            end
        end
    end

    always_comb begin
        w_src1 = '0;
        w_src2 = '0;
        w_fsel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == PTR_W'(i)) begin
                w_src1 = req_src1[i*32 +: 32];
                w_src2 = req_src2[i*32 +: 32];
                w_fsel = req_fsel[i*2 +: 2];
            end
        end
    end

    assign w_next_ptr = (w_grant == PTR_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;

    assign w_hit = (MEMO_EN != 0) && r_memo_valid &&
                   (w_src1 == r_memo_a) && (w_src2 == r_memo_b) &&
                   (r_memo_signed == ~w_fsel[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_memo_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_src1   <= w_src1;
                        r_src2   <= w_src2;
                        r_fsel   <= w_fsel;
                        r_tag    <= w_grant;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= w_hit ? S_RESP : S_RUN;
                    end
                end
                S_RUN: r_state <= S_WAIT;
                S_WAIT: begin
                    if (div_complete) begin
                        r_memo_q      <= div0 ? 32'hFFFF_FFFF : div_quotient[31:0];
                        r_memo_r      <= div_rem[31:0];
                        r_memo_a      <= r_src1;
                        r_memo_b      <= r_src2;
                        r_memo_signed <= ~r_fsel[0];
                        r_memo_valid  <= 1'b1;
                        r_state       <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bit 32 carries the sign only for signed ops, so the divider always sees
    // exact 33-bit two's-complement values and needs no overflow special case.
    assign div_src1 = {~r_fsel[0] & r_src1[31], r_src1};
    assign div_src2 = {~r_fsel[0] & r_src2[31], r_src2};

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i]  = !rst && (r_state == S_IDLE) && w_any && (w_grant == PTR_W'(i));
            resp_valid[i] = !rst && (r_state == S_RESP) && (r_tag == PTR_W'(i));
        end
    end

    assign div_start = !rst && (r_state == S_RUN);
    assign busy      = !rst && (r_state != S_IDLE);
    assign resp_data = (!rst && (r_state == S_RESP)) ? (r_fsel[1] ? r_memo_r : r_memo_q) : 32'h0;

    assign w_unused_bits = ^{div_quotient[32], div_rem[32]};

endmodule
`default_nettype wire

// File: tb/tb_rvtu_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvtu_div_sched
//  Description : Self-checking bench for rvtu_div_sched with a divider model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvtu_div_sched;

    localparam int NREQ    = 4;
    localparam int MEMO_EN = 1;
    localparam int DIV_LAT = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_src1;
    logic [NREQ*32-1:0]  req_src2;
    logic [NREQ*2-1:0]   req_fsel;
    logic [NREQ-1:0]     resp_valid;
    logic [31:0]         resp_data;
    logic                div_start;
    logic [32:0]         div_src1;
    logic [32:0]         div_src2;
    logic                div_complete;
    logic                div0;
    logic [32:0]         div_quotient;
    logic [32:0]         div_rem;
    logic                busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Abstract memo state: operands of the last divider pass.
    bit          m_valid = 1'b0;
    logic [31:0] m_a;
    logic [31:0] m_b;
    bit          m_signed;

    rvtu_div_sched #(.NREQ(NREQ), .MEMO_EN(MEMO_EN)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_fsel     (req_fsel),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .div_start    (div_start),
        .div_src1     (div_src1),
        .div_src2     (div_src2),
        .div_complete (div_complete),
        .div0         (div0),
        .div_quotient (div_quotient),
        .div_rem      (div_rem),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Sequential divider model: 33-bit signed, completes DIV_LAT cycles after start.
    int                 d_cnt = 0;
    logic signed [32:0] d_a;
    logic signed [32:0] d_b;
    initial begin
        div_complete = 1'b0;
        div0         = 1'b0;
        div_quotient = '0;
        div_rem      = '0;
    end
    always @(negedge clk) begin
        div_complete = 1'b0;
        if (rst) begin
            d_cnt = 0;
        end else if (d_cnt > 0) begin
            d_cnt = d_cnt - 1;
            if (d_cnt == 0) begin
                div_complete = 1'b1;
                div0         = (d_b == 0);
                div_quotient = (d_b == 0) ? '1 : 33'(d_a / d_b);
                div_rem      = (d_b == 0) ? d_a : 33'(d_a % d_b);
            end
        end else if (div_start) begin
            d_a   = div_src1;
            d_b   = div_src2;
            d_cnt = DIV_LAT;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // RISC-V M result computed directly on 32-bit operands.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] fsel);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!fsel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (!fsel[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return fsel[1] ? r : q;
    endfunction

    function automatic bit memo_hit(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fsel);
        return (MEMO_EN != 0) && m_valid && (a == m_a) && (b == m_b) && (m_signed == !fsel[0]);
    endfunction

    // Called at the accept cycle; follows the request to its response.
    task automatic wait_resp(input int lane, input logic [31:0] exp_data, input bit exp_hit,
                             input bit drop, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] fsel);
        int cycles = 0;
        int starts = 0;
        bit start1 = 1'b0;
        bit got    = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (drop) req_valid[lane] = 1'b0;
            cycles++;
            if (div_start) begin
                starts++;
                if (cycles == 1) start1 = 1'b1;
            end
            if (resp_valid != '0) got = 1'b1;
        end
        check("resp_seen", 32'(got), 32'd1);
        check("resp_lane", 32'(resp_valid), 32'(1 << lane));
        check("resp_data", resp_data, exp_data);
        check("latency", cycles, exp_hit ? 32'd1 : 32'(DIV_LAT + 2));
        check("start_count", starts, exp_hit ? 32'd0 : 32'd1);
        if (!exp_hit) begin
            check("start_after_accept", 32'(start1), 32'd1);
            m_valid  = 1'b1;
            m_a      = a;
            m_b      = b;
            m_signed = !fsel[0];
        end
    endtask

    task automatic run_op(input int lane, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] fsel, input logic [31:0] exp_data);
        bit hit;
        bit found = 1'b0;
        hit = memo_hit(a, b, fsel);
        @(negedge clk);
        req_src1[lane*32 +: 32] = a;
        req_src2[lane*32 +: 32] = b;
        req_fsel[lane*2 +: 2]   = fsel;
        req_valid[lane]         = 1'b1;
        #1;
        for (int c = 0; c < 40 && !found; c++) begin
            if (req_ready[lane]) found = 1'b1;
            else @(negedge clk);
        end
        check("accept", 32'(found), 32'd1);
        check("ready_vec", 32'(req_ready), 32'(1 << lane));
        if (found) wait_resp(lane, exp_data, hit, 1'b1, a, b, fsel);
        else req_valid[lane] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  f;
        int          lane;
        int          mode;
        bit          found;
        bit          stray;

        rst       = 1'b1;
        req_valid = '1;
        req_src1  = '0;
        req_src2  = '0;
        req_fsel  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;

        // Directed cases from the test plan
        run_op(0, 32'd100, 32'd7, 2'b00, 32'd14);
        run_op(0, 32'd100, 32'd7, 2'b10, 32'd2);
        run_op(1, 32'd5, 32'd0, 2'b01, 32'hFFFF_FFFF);
        run_op(1, 32'd5, 32'd0, 2'b11, 32'd5);
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000);
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0);
        run_op(3, 32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD);
        run_op(3, 32'hFFFF_FFF9, 32'd2, 2'b01, 32'h7FFF_FFFC);
        run_op(3, 32'hFFFF_FFF9, 32'd2, 2'b10, 32'hFFFF_FFFF);

        // All lanes contend after reset: grants must rotate 0,1,2,3,0
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            req_src1[i*32 +: 32] = 32'(1000 + 37 * i);
            req_src2[i*32 +: 32] = 32'(i + 3);
            req_fsel[i*2 +: 2]   = 2'b00;
        end
        req_valid = '1;
        #1;
        for (int g = 0; g < 5; g++) begin
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                if (req_ready != '0) found = 1'b1;
                else @(negedge clk);
            end
            check("rr_accept", 32'(found), 32'd1);
            check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
            lane = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) lane = i;
            check("rr_grant", lane, 32'(g % NREQ));
            a = req_src1[lane*32 +: 32];
            b = req_src2[lane*32 +: 32];
            f = req_fsel[lane*2 +: 2];
            wait_resp(lane, ref_result(a, b, f), memo_hit(a, b, f), 1'b0, a, b, f);
        end
        req_valid = '0;

        // Reset while waiting on the divider aborts the operation and the memo
        @(negedge clk);
        req_src1[2*32 +: 32] = 32'd12345;
        req_src2[2*32 +: 32] = 32'd67;
        req_fsel[2*2 +: 2]   = 2'b00;
        req_valid[2]         = 1'b1;
        req_valid[0]         = 1'b1;
        #1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (req_ready != '0) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_accept", 32'(found), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        m_valid   = 1'b0;
        stray     = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid != '0) stray = 1'b1;
        end
        check("abort_no_resp", 32'(stray), 32'd0);
        run_op(2, 32'd12345, 32'd67, 2'b00, 32'd184);
        run_op(0, 32'd100, 32'd7, 2'b00, 32'd14);

        // Randomized traffic against the reference model
        a = $urandom;
        b = $urandom;
        for (int n = 0; n < 40; n++) begin
            lane = $urandom_range(0, NREQ - 1);
            mode = $urandom_range(0, 7);
            if (mode == 3) begin
                a = $urandom;
                b = 32'h0;
            end else if (mode == 4) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (mode >= 5) begin
                a = $urandom;
                b = (mode == 5) ? 32'($urandom_range(1, 1000)) : $urandom;
            end
            f = 2'($urandom_range(0, 3));
            run_op(lane, a, b, f, ref_result(a, b, f));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
